// File: rtl/app_axil_cmd.sv
// Single-outstanding command to AXI-lite master bridge with response buffer and error counter.
// Optional wait-state timeout is enabled by defining APP_AXIL_TIMEOUT_EN.
module app_axil_cmd #(
  parameter int AXIL_ADDR_WIDTH = 16,
  parameter int AXIL_DATA_WIDTH = 32,
  parameter int AXIL_STRB_WIDTH = AXIL_DATA_WIDTH/8,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                       clk,
  input  logic                       rst,

  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic                       cmd_write,
  input  logic [AXIL_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [AXIL_DATA_WIDTH-1:0] cmd_wdata,
  input  logic [AXIL_STRB_WIDTH-1:0] cmd_wstrb,

  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic                       rsp_write,
  output logic [AXIL_DATA_WIDTH-1:0] rsp_data,
  output logic [1:0]                 rsp_resp,
  output logic                       rsp_timeout,

  output logic [AXIL_ADDR_WIDTH-1:0] m_axil_awaddr,
  output logic [2:0]                 m_axil_awprot,
  output logic                       m_axil_awvalid,
  input  logic                       m_axil_awready,
  output logic [AXIL_DATA_WIDTH-1:0] m_axil_wdata,
  output logic [AXIL_STRB_WIDTH-1:0] m_axil_wstrb,
  output logic                       m_axil_wvalid,
  input  logic                       m_axil_wready,
  input  logic [1:0]                 m_axil_bresp,
  input  logic                       m_axil_bvalid,
  output logic                       m_axil_bready,
  output logic [AXIL_ADDR_WIDTH-1:0] m_axil_araddr,
  output logic [2:0]                 m_axil_arprot,
  output logic                       m_axil_arvalid,
  input  logic                       m_axil_arready,
  input  logic [AXIL_DATA_WIDTH-1:0] m_axil_rdata,
  input  logic [1:0]                 m_axil_rresp,
  input  logic                       m_axil_rvalid,
  output logic                       m_axil_rready,

  output logic [15:0]                err_count,
  output logic                       busy
);

  typedef enum logic [2:0] {IDLE, WR, WR_B, RD_AR, RD_R, RSP} state_t;

  state_t                     state_q, state_d;
  logic [AXIL_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [AXIL_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [AXIL_STRB_WIDTH-1:0] strb_q, strb_d;
  logic                       write_q, write_d;
  logic                       aw_done_q, aw_done_d;
  logic                       w_done_q, w_done_d;
  logic [AXIL_DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [1:0]                 rsp_resp_q, rsp_resp_d;
  logic [15:0]                err_q, err_d;

  logic aw_hs, w_hs;

`ifdef APP_AXIL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q, tmo_d;
  logic          rsp_tmo_q, rsp_tmo_d;
  logic          wait_st, tmo_hit;

  assign wait_st = (state_q == WR) || (state_q == WR_B) || (state_q == RD_AR) || (state_q == RD_R);
  assign tmo_hit = wait_st && (tmo_q == TW'(TIMEOUT_CYCLES - 1));
  assign rsp_timeout = rsp_tmo_q;
`else
  logic [31:0] unused_tmo;
  assign unused_tmo  = 32'(TIMEOUT_CYCLES);
  assign rsp_timeout = 1'b0;
`endif

  // Valid/ready are pure decodes of state so reset clears them combinationally.
  assign cmd_ready      = (state_q == IDLE);
  assign busy           = (state_q != IDLE);
  assign m_axil_awvalid = (state_q == WR) && !aw_done_q;
  assign m_axil_wvalid  = (state_q == WR) && !w_done_q;
  assign m_axil_bready  = (state_q == WR_B);
  assign m_axil_arvalid = (state_q == RD_AR);
  assign m_axil_rready  = (state_q == RD_R);
  assign m_axil_awaddr  = addr_q;
  assign m_axil_araddr  = addr_q;
  assign m_axil_wdata   = wdata_q;
  assign m_axil_wstrb   = strb_q;
  assign m_axil_awprot  = 3'b000;
  assign m_axil_arprot  = 3'b000;

  assign rsp_valid = (state_q == RSP);
  assign rsp_write = write_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_resp  = rsp_resp_q;
  assign err_count = err_q;

  assign aw_hs = m_axil_awvalid && m_axil_awready;
  assign w_hs  = m_axil_wvalid && m_axil_wready;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    strb_d     = strb_q;
    write_d    = write_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    rsp_data_d = rsp_data_q;
    rsp_resp_d = rsp_resp_q;
    err_d      = err_q;
`ifdef APP_AXIL_TIMEOUT_EN
    rsp_tmo_d  = rsp_tmo_q;
    tmo_d      = tmo_q;
`endif

    case (state_q)
      IDLE: if (cmd_valid) begin
        addr_d  = cmd_addr;
        wdata_d = cmd_wdata;
        strb_d  = cmd_wstrb;
        write_d = cmd_write;
        state_d = cmd_write ? WR : RD_AR;
      end
      WR: begin
        // AW and W complete independently, in either order or together.
        if (aw_hs) aw_done_d = 1'b1;
        if (w_hs)  w_done_d  = 1'b1;
        if (aw_done_d && w_done_d) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = WR_B;
        end
      end
      WR_B: if (m_axil_bvalid) begin
        rsp_data_d = '0;
        rsp_resp_d = m_axil_bresp;
`ifdef APP_AXIL_TIMEOUT_EN
        rsp_tmo_d  = 1'b0;
`endif
        state_d    = RSP;
      end
      RD_AR: if (m_axil_arready) state_d = RD_R;
      RD_R: if (m_axil_rvalid) begin
        rsp_data_d = m_axil_rdata;
        rsp_resp_d = m_axil_rresp;
`ifdef APP_AXIL_TIMEOUT_EN
        rsp_tmo_d  = 1'b0;
`endif
        state_d    = RSP;
      end
      RSP: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase

`ifdef APP_AXIL_TIMEOUT_EN
    // Timeout wins over any handshake landing in the same cycle.
    if (tmo_hit) begin
      state_d    = RSP;
      rsp_data_d = '0;
      rsp_resp_d = 2'b10;
      rsp_tmo_d  = 1'b1;
      aw_done_d  = 1'b0;
      w_done_d   = 1'b0;
    end
    if (state_d != state_q) tmo_d = '0;
    else if (wait_st)       tmo_d = tmo_q + 1'b1;
    else                    tmo_d = '0;
`endif

    if ((state_q != RSP) && (state_d == RSP) && (rsp_resp_d != 2'b00) && (err_q != 16'hFFFF))
      err_d = err_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      strb_q     <= '0;
      write_q    <= 1'b0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      rsp_data_q <= '0;
      rsp_resp_q <= 2'b00;
      err_q      <= 16'd0;
`ifdef APP_AXIL_TIMEOUT_EN
      rsp_tmo_q  <= 1'b0;
      tmo_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      strb_q     <= strb_d;
      write_q    <= write_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
      rsp_data_q <= rsp_data_d;
      rsp_resp_q <= rsp_resp_d;
      err_q      <= err_d;
`ifdef APP_AXIL_TIMEOUT_EN
      rsp_tmo_q  <= rsp_tmo_d;
      tmo_q      <= tmo_d;
`endif
    end
  end

endmodule

// File: tb/tb_app_axil_cmd.sv
// Directed vector bench for app_axil_cmd with a delay-configurable AXI-lite slave.
module tb_app_axil_cmd;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [15:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_write, rsp_timeout;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_resp;
  logic [15:0] m_axil_awaddr, m_axil_araddr;
  logic [2:0]  m_axil_awprot, m_axil_arprot;
  logic        m_axil_awvalid, m_axil_wvalid, m_axil_bready, m_axil_arvalid, m_axil_rready;
  logic [31:0] m_axil_wdata;
  logic [3:0]  m_axil_wstrb;
  logic        m_axil_awready = 0, m_axil_wready = 0, m_axil_bvalid = 0;
  logic        m_axil_arready = 0, m_axil_rvalid = 0;
  logic [15:0] err_count;
  logic        busy;

  // slave configuration, written by the stimulus
  int          aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  logic [1:0]  bresp_cfg = 0, rresp_cfg = 0;
  logic [31:0] rdata_cfg = 0;

  // slave state, written only by the slave process
  int          aw_wait = 0, w_wait = 0, b_wait = 0, ar_wait = 0, r_wait = 0;
  int          aw_beats = 0, w_beats = 0, b_beats = 0, ar_beats = 0, r_beats = 0, viol = 0;
  bit          got_aw = 0, got_w = 0, got_ar = 0, aw_stall = 0, w_stall = 0, ar_stall = 0;
  logic [15:0] aw_addr_s = 0, ar_addr_s = 0, cap_awaddr = 0, cap_araddr = 0;
  logic [31:0] w_data_s = 0, cap_wdata = 0;
  logic [3:0]  w_strb_s = 0, cap_wstrb = 0;

  int tests = 0, fails = 0;
  logic [15:0] exp_err = 0;

  always #5 clk = ~clk;

  app_axil_cmd #(.AXIL_ADDR_WIDTH(16), .AXIL_DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_data(rsp_data), .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
    .m_axil_awaddr(m_axil_awaddr), .m_axil_awprot(m_axil_awprot),
    .m_axil_awvalid(m_axil_awvalid), .m_axil_awready(m_axil_awready),
    .m_axil_wdata(m_axil_wdata), .m_axil_wstrb(m_axil_wstrb),
    .m_axil_wvalid(m_axil_wvalid), .m_axil_wready(m_axil_wready),
    .m_axil_bresp(bresp_cfg), .m_axil_bvalid(m_axil_bvalid), .m_axil_bready(m_axil_bready),
    .m_axil_araddr(m_axil_araddr), .m_axil_arprot(m_axil_arprot),
    .m_axil_arvalid(m_axil_arvalid), .m_axil_arready(m_axil_arready),
    .m_axil_rdata(rdata_cfg), .m_axil_rresp(rresp_cfg),
    .m_axil_rvalid(m_axil_rvalid), .m_axil_rready(m_axil_rready),
    .err_count(err_count), .busy(busy)
  );

  // Slave: decides ready/valid on the falling edge; a handshake seen here completes on the next rise.
  always @(negedge clk) begin
    if (!rst) begin
      m_axil_awready = 0; m_axil_wready = 0; m_axil_bvalid = 0; m_axil_arready = 0; m_axil_rvalid = 0;
      aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
      got_aw = 0; got_w = 0; got_ar = 0; aw_stall = 0; w_stall = 0; ar_stall = 0;
    end else begin
      if (aw_stall && (!m_axil_awvalid || m_axil_awaddr != aw_addr_s)) viol++;
      if (w_stall && (!m_axil_wvalid || m_axil_wdata != w_data_s || m_axil_wstrb != w_strb_s)) viol++;
      if (ar_stall && (!m_axil_arvalid || m_axil_araddr != ar_addr_s)) viol++;
      if (m_axil_bready && !(got_aw && got_w)) viol++;
      if (m_axil_rready && !got_ar) viol++;
      if ((m_axil_awprot | m_axil_arprot) != 3'b000) viol++;

      if (got_aw && got_w) begin b_wait++; m_axil_bvalid = (b_wait > b_dly); end
      else begin b_wait = 0; m_axil_bvalid = 0; end
      if (m_axil_bvalid && m_axil_bready) begin got_aw = 0; got_w = 0; b_beats++; end

      if (m_axil_awvalid) begin aw_wait++; m_axil_awready = (aw_wait > aw_dly); end
      else begin aw_wait = 0; m_axil_awready = 0; end
      aw_stall = m_axil_awvalid && !m_axil_awready; aw_addr_s = m_axil_awaddr;
      if (m_axil_awvalid && m_axil_awready) begin got_aw = 1; aw_beats++; cap_awaddr = m_axil_awaddr; end

      if (m_axil_wvalid) begin w_wait++; m_axil_wready = (w_wait > w_dly); end
      else begin w_wait = 0; m_axil_wready = 0; end
      w_stall = m_axil_wvalid && !m_axil_wready; w_data_s = m_axil_wdata; w_strb_s = m_axil_wstrb;
      if (m_axil_wvalid && m_axil_wready) begin
        got_w = 1; w_beats++; cap_wdata = m_axil_wdata; cap_wstrb = m_axil_wstrb;
      end

      if (got_ar) begin r_wait++; m_axil_rvalid = (r_wait > r_dly); end
      else begin r_wait = 0; m_axil_rvalid = 0; end
      if (m_axil_rvalid && m_axil_rready) begin got_ar = 0; r_beats++; end

      if (m_axil_arvalid) begin ar_wait++; m_axil_arready = (ar_wait > ar_dly); end
      else begin ar_wait = 0; m_axil_arready = 0; end
      ar_stall = m_axil_arvalid && !m_axil_arready; ar_addr_s = m_axil_araddr;
      if (m_axil_arvalid && m_axil_arready) begin got_ar = 1; ar_beats++; cap_araddr = m_axil_araddr; end
    end
  end

  typedef struct {
    logic        write;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [1:0]  resp;
    logic [31:0] rdata;
    int          aw_d, w_d, b_d, ar_d, r_d;
    logic [31:0] exp_data;
    int          exp_lat;
  } vec_t;

  function automatic vec_t mk(input logic wr, input logic [15:0] a, input logic [31:0] wd,
                              input logic [3:0] s, input logic [1:0] rs, input logic [31:0] rd,
                              input int awd, input int wdl, input int bd, input int ard, input int rdl,
                              input logic [31:0] ed, input int el);
    vec_t v;
    v.write = wr; v.addr = a; v.wdata = wd; v.strb = s; v.resp = rs; v.rdata = rd;
    v.aw_d = awd; v.w_d = wdl; v.b_d = bd; v.ar_d = ard; v.r_d = rdl;
    v.exp_data = ed; v.exp_lat = el;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_cmd(input vec_t v, input int hold, input string tag);
    int n, lat, aw0, w0, ar0;
    logic [31:0] d0;
    logic [1:0] r0;
    bit bad;
    aw_dly = v.aw_d; w_dly = v.w_d; b_dly = v.b_d; ar_dly = v.ar_d; r_dly = v.r_d;
    bresp_cfg = v.resp; rresp_cfg = v.resp; rdata_cfg = v.rdata;
    aw0 = aw_beats; w0 = w_beats; ar0 = ar_beats;
    cmd_valid = 1; cmd_write = v.write; cmd_addr = v.addr; cmd_wdata = v.wdata; cmd_wstrb = v.strb;
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    chk({tag, ".accept"}, cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 0; cmd_wdata = '0; cmd_addr = '0;
    lat = 1;
    while (!rsp_valid && lat < 300) begin @(negedge clk); lat++; end
    chk({tag, ".latency"}, lat, v.exp_lat);
    chk({tag, ".rsp_data"}, rsp_data, v.exp_data);
    chk({tag, ".rsp_resp"}, rsp_resp, v.resp);
    chk({tag, ".rsp_write"}, rsp_write, v.write);
    chk({tag, ".rsp_timeout"}, rsp_timeout, 0);
    chk({tag, ".cmd_ready_in_rsp"}, cmd_ready, 0);
    if (v.write) begin
      chk({tag, ".aw_beats"}, aw_beats - aw0, 1);
      chk({tag, ".w_beats"}, w_beats - w0, 1);
      chk({tag, ".awaddr"}, cap_awaddr, v.addr);
      chk({tag, ".wdata"}, cap_wdata, v.wdata);
      chk({tag, ".wstrb"}, cap_wstrb, v.strb);
      chk({tag, ".ar_beats"}, ar_beats - ar0, 0);
    end else begin
      chk({tag, ".ar_beats"}, ar_beats - ar0, 1);
      chk({tag, ".araddr"}, cap_araddr, v.addr);
      chk({tag, ".aw_beats"}, aw_beats - aw0, 0);
    end
    if (v.resp != 2'b00 && exp_err != 16'hFFFF) exp_err++;
    chk({tag, ".err_count"}, err_count, exp_err);
    d0 = rsp_data; r0 = rsp_resp; bad = 0;
    repeat (hold) begin
      @(negedge clk);
      if (!rsp_valid || rsp_data !== d0 || rsp_resp !== r0 || cmd_ready !== 1'b0) bad = 1;
    end
    if (hold > 0) chk({tag, ".rsp_hold_stable"}, bad, 0);
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
    chk({tag, ".rsp_done"}, rsp_valid, 0);
    chk({tag, ".back_idle"}, cmd_ready, 1);
    chk({tag, ".protocol"}, viol, 0);
  endtask

  vec_t vecs[8];
  vec_t tv;

  initial begin
    int n;
    rst = 0; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0; rsp_ready = 0;

    //             wr  addr      wdata         strb  resp   rdata         aw w  b  ar r  exp_data      lat
    vecs[0] = mk(1, 16'h0010, 32'hDEADBEEF, 4'hF, 2'b00, 32'h0,        0, 0, 0, 0, 0, 32'h0,        3);
    vecs[1] = mk(0, 16'h0020, 32'h0,        4'h0, 2'b00, 32'h12345678, 0, 0, 0, 0, 5, 32'h12345678, 8);
    vecs[2] = mk(1, 16'h0100, 32'hA5A50001, 4'hF, 2'b00, 32'h0,        0, 4, 0, 0, 0, 32'h0,        7);
    vecs[3] = mk(1, 16'h0104, 32'h00005A5A, 4'h3, 2'b00, 32'h0,        4, 0, 0, 0, 0, 32'h0,        7);
    vecs[4] = mk(0, 16'h0200, 32'h0,        4'h0, 2'b10, 32'hCAFEF00D, 0, 0, 0, 2, 0, 32'hCAFEF00D, 5);
    vecs[5] = mk(1, 16'h0300, 32'h11223344, 4'h8, 2'b11, 32'h0,        0, 0, 3, 0, 0, 32'h0,        6);
    vecs[6] = mk(0, 16'hFFFC, 32'h0,        4'h0, 2'b01, 32'hFFFFFFFF, 0, 0, 0, 1, 1, 32'hFFFFFFFF, 5);
    vecs[7] = mk(1, 16'h0400, 32'h0BADF00D, 4'h5, 2'b00, 32'h0,        2, 2, 0, 0, 0, 32'h0,        5);

    repeat (3) @(negedge clk);
    chk("reset.cmd_ready", cmd_ready, 1);
    chk("reset.busy", busy, 0);
    chk("reset.rsp_valid", rsp_valid, 0);
    chk("reset.err_count", err_count, 0);
    chk("reset.rsp_payload", {rsp_data, rsp_resp, rsp_timeout}, 0);
    chk("reset.axi_vr", {m_axil_awvalid, m_axil_wvalid, m_axil_bready, m_axil_arvalid, m_axil_rready}, 0);
    rst = 1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) do_cmd(vecs[i], 0, $sformatf("vec%0d", i));

    // three error responses, the first held off by the consumer for 10 cycles
    tv = mk(1, 16'h0500, 32'h55AA55AA, 4'hF, 2'b10, 32'h0, 0, 0, 0, 0, 0, 32'h0, 3);
    n = int'(exp_err);
    do_cmd(tv, 10, "err3.a");
    tv = mk(0, 16'h0504, 32'h0, 4'h0, 2'b10, 32'h87654321, 0, 0, 0, 0, 0, 32'h87654321, 3);
    do_cmd(tv, 0, "err3.b");
    tv = mk(1, 16'h0508, 32'h01020304, 4'h1, 2'b10, 32'h0, 0, 0, 0, 0, 0, 32'h0, 3);
    do_cmd(tv, 0, "err3.c");
    chk("err3.total", err_count, 16'(n + 3));

    // reset while waiting for B
    aw_dly = 0; w_dly = 0; b_dly = 30; bresp_cfg = 2'b00;
    cmd_valid = 1; cmd_write = 1; cmd_addr = 16'h0600; cmd_wdata = 32'hFEEDFACE; cmd_wstrb = 4'hF;
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    cmd_valid = 0;
    n = 0;
    while (!m_axil_bready && n < 20) begin @(negedge clk); n++; end
    chk("rstwb.in_wr_b", m_axil_bready, 1);
    #2 rst = 0;
    #1;
    chk("rstwb.busy", busy, 0);
    chk("rstwb.cmd_ready", cmd_ready, 1);
    chk("rstwb.err_count", err_count, 0);
    chk("rstwb.rsp", {rsp_valid, rsp_data, rsp_resp, rsp_timeout}, 0);
    chk("rstwb.axi_vr", {m_axil_awvalid, m_axil_wvalid, m_axil_bready, m_axil_arvalid, m_axil_rready}, 0);
    exp_err = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("rstwb.post_cmd_ready", cmd_ready, 1);
    chk("rstwb.post_no_rsp", rsp_valid, 0);
    do_cmd(vecs[0], 0, "rstwb.next");

    // slave never accepts AR
    ar_dly = 100000;
    cmd_valid = 1; cmd_write = 0; cmd_addr = 16'h0700;
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    cmd_valid = 0;
    n = 0;
    while (m_axil_arvalid && n < 100) begin n++; @(negedge clk); end
`ifdef APP_AXIL_TIMEOUT_EN
    chk("tmo.ar_cycles", n, 16);
    chk("tmo.arvalid", m_axil_arvalid, 0);
    chk("tmo.rsp_valid", rsp_valid, 1);
    chk("tmo.rsp_resp", rsp_resp, 2'b10);
    chk("tmo.rsp_timeout", rsp_timeout, 1);
    chk("tmo.rsp_data", rsp_data, 0);
    exp_err++;
    chk("tmo.err_count", err_count, exp_err);
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
    chk("tmo.back_idle", cmd_ready, 1);
`else
    chk("hang.ar_cycles", n, 100);
    chk("hang.arvalid", m_axil_arvalid, 1);
    chk("hang.no_rsp", rsp_valid, 0);
    rst = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1;
    exp_err = 0;
    @(negedge clk);
    chk("hang.recovered", cmd_ready, 1);
`endif
    do_cmd(vecs[1], 0, "final.read");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
